// File: rtl/pio_cmd_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : pio_cmd_engine_if
// Description : Single-port synchronous frame-buffer RAM bus between the PIO
//               command engine (master) and the image memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pio_cmd_engine_if #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_addr,
      output mem_wdata,
      output mem_we,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_wdata,
      input  mem_we,
      output mem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/pio_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module      : pio_cmd_engine
// Description : Decodes HPS PIO instruction words launched on pio_enable
//               rising edges and runs NOP/WRITE/READ/FILL against the RAM.
//               Optional even-parity check on bit 28: PIO_CMD_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pio_cmd_engine #(
   parameter int ADDR_W    = 17,
   parameter int DATA_W    = 8,
   parameter int MEM_DEPTH = 76800,
   parameter int RD_LAT    = 2
) (
   input  logic                       clk_clk,
   input  logic                       reset_reset,
   input  logic [ADDR_W+DATA_W+3:0]   pio_instruct,
   input  logic                       pio_enable,
   output logic [DATA_W-1:0]          pio_data_out,
   output logic [3:0]                 pio_flags,
   pio_cmd_engine_if.master           mem
);

   localparam int c_body_w = ADDR_W + DATA_W + 3;

   localparam logic [2:0] c_op_nop   = 3'd0;
   localparam logic [2:0] c_op_write = 3'd1;
   localparam logic [2:0] c_op_read  = 3'd2;
   localparam logic [2:0] c_op_fill  = 3'd3;

   localparam logic [2:0] c_st_idle      = 3'd0;
   localparam logic [2:0] c_st_decode    = 3'd1;
   localparam logic [2:0] c_st_write     = 3'd2;
   localparam logic [2:0] c_st_read_wait = 3'd3;
   localparam logic [2:0] c_st_fill      = 3'd4;
   localparam logic [2:0] c_st_nop       = 3'd5;
   localparam logic [2:0] c_st_done      = 3'd6;

   localparam logic [ADDR_W:0]   c_depth  = (ADDR_W+1)'(MEM_DEPTH);
   localparam logic [ADDR_W-1:0] c_last   = ADDR_W'(MEM_DEPTH - 1);
   localparam logic [2:0]        c_rd_lat = 3'(RD_LAT);

   logic [2:0]          r_state;
   logic                r_enable_q;
   logic [c_body_w-1:0] r_instr;
   logic [2:0]          r_cnt;
   logic                r_done;
   logic                r_op_err;
   logic                r_busy;
   logic                r_addr_err;
   logic [DATA_W-1:0]   r_data_out;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic                r_mem_we;

   logic                w_launch;
   logic [2:0]          w_op;
   logic [ADDR_W-1:0]   w_addr;
   logic [DATA_W-1:0]   w_data;
   logic                w_addr_ok;
   logic                w_parity_bad;

   assign w_launch  = pio_enable & ~r_enable_q;
   assign w_op      = r_instr[2:0];
   assign w_addr    = r_instr[3 +: ADDR_W];
   assign w_data    = r_instr[3+ADDR_W +: DATA_W];
   assign w_addr_ok = ({1'b0, w_addr} < c_depth);

`ifdef PIO_CMD_PARITY_EN
   logic r_parity;
   // Even parity over the full word: stored bit XOR body must be zero.
   assign w_parity_bad = r_parity ^ (^r_instr);
`else
   logic w_unused;
   assign w_unused     = pio_instruct[c_body_w];
   assign w_parity_bad = 1'b0;
`endif

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         r_state     <= c_st_idle;
         r_enable_q  <= 1'b1;
         r_instr     <= '0;
         r_cnt       <= '0;
         r_done      <= 1'b0;
         r_op_err    <= 1'b0;
         r_busy      <= 1'b0;
         r_addr_err  <= 1'b0;
         r_data_out  <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_we    <= 1'b0;
`ifdef PIO_CMD_PARITY_EN
         r_parity    <= 1'b0;
`endif
      end else begin
         r_enable_q <= pio_enable;
         case (r_state)
            c_st_idle: begin
               if (w_launch) begin
                  r_instr    <= pio_instruct[c_body_w-1:0];
`ifdef PIO_CMD_PARITY_EN
                  r_parity   <= pio_instruct[c_body_w];
`endif
                  r_done     <= 1'b0;
                  r_op_err   <= 1'b0;
                  r_addr_err <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= c_st_decode;
               end
            end
            c_st_decode: begin
               if (w_parity_bad || (w_op > c_op_fill)) begin
                  r_op_err <= 1'b1;
                  r_state  <= c_st_done;
               end else if (((w_op == c_op_write) || (w_op == c_op_read)) && !w_addr_ok) begin
                  r_addr_err <= 1'b1;
                  r_state    <= c_st_done;
               end else begin
                  case (w_op)
                     // NOP spends one idle execute cycle so it matches WRITE timing.
                     c_op_nop: r_state <= c_st_nop;
                     c_op_write: begin
                        r_mem_addr  <= w_addr;
                        r_mem_wdata <= w_data;
                        r_mem_we    <= 1'b1;
                        r_state     <= c_st_write;
                     end
                     c_op_read: begin
                        r_mem_addr <= w_addr;
                        r_cnt      <= '0;
                        r_state    <= c_st_read_wait;
                     end
                     default: begin
                        r_mem_addr  <= '0;
                        r_mem_wdata <= w_data;
                        r_mem_we    <= 1'b1;
                        r_state     <= c_st_fill;
                     end
                  endcase
               end
            end
            c_st_write: begin
               r_mem_we <= 1'b0;
               r_state  <= c_st_done;
            end
            c_st_nop: begin
               r_state <= c_st_done;
            end
            c_st_read_wait: begin
               // Data is valid RD_LAT edges after the address; sample on the following edge.
               if (r_cnt == c_rd_lat) begin
                  r_data_out <= mem.mem_rdata;
                  r_state    <= c_st_done;
               end else begin
                  r_cnt <= r_cnt + 3'd1;
               end
            end
            c_st_fill: begin
               if (r_mem_addr == c_last) begin
                  r_mem_we <= 1'b0;
                  r_state  <= c_st_done;
               end else begin
                  r_mem_addr <= r_mem_addr + ADDR_W'(1);
               end
            end
            c_st_done: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= c_st_idle;
            end
            default: begin
               r_mem_we <= 1'b0;
               r_state  <= c_st_idle;
            end
         endcase
      end
   end

   assign pio_data_out  = r_data_out;
   assign pio_flags     = {r_addr_err, r_busy, r_op_err, r_done};
   assign mem.mem_addr  = r_mem_addr;
   assign mem.mem_wdata = r_mem_wdata;
   assign mem.mem_we    = r_mem_we;

endmodule
`default_nettype wire

// File: tb/tb_pio_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_pio_cmd_engine
// Description : Directed bench for pio_cmd_engine with a small RAM, a
//               command-level reference model and a per-cycle comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_cmd_engine;

   localparam int DEPTH  = 16;
   localparam int RD_LAT = 2;

   logic        clk;
   logic        rst;
   logic [28:0] instr;
   logic        en;
   logic [7:0]  data_out;
   logic [3:0]  flags;

   pio_cmd_engine_if #(.ADDR_W(17), .DATA_W(8)) mif ();

   pio_cmd_engine #(
      .ADDR_W(17), .DATA_W(8), .MEM_DEPTH(DEPTH), .RD_LAT(RD_LAT)
   ) dut (
      .clk_clk(clk), .reset_reset(rst), .pio_instruct(instr), .pio_enable(en),
      .pio_data_out(data_out), .pio_flags(flags), .mem(mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM with RD_LAT-stage read pipeline
   logic [7:0] ram [0:DEPTH-1];
   logic [7:0] rd_pipe [0:RD_LAT-1];
   initial begin
      for (int i = 0; i < DEPTH; i++) ram[i] = 8'h00;
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = 8'h00;
   end
   always @(posedge clk) begin
      if (mif.mem_we && (mif.mem_addr < 17'(DEPTH))) ram[mif.mem_addr[3:0]] <= mif.mem_wdata;
      rd_pipe[0] <= (mif.mem_addr < 17'(DEPTH)) ? ram[mif.mem_addr[3:0]] : 8'h00;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mif.mem_rdata = rd_pipe[RD_LAT-1];

   int we_total = 0;
   always @(posedge clk) if (mif.mem_we) we_total++;

   // ---------------- reference model ----------------
   logic [7:0]  gold [0:DEPTH-1];
   initial for (int i = 0; i < DEPTH; i++) gold[i] = 8'h00;
   bit          m_busy = 0, m_prev_en = 1, m_done = 0, m_operr = 0, m_adderr = 0;
   bit          m_oe_c = 0, m_ae_c = 0, m_rst_edge = 0;
   int          m_k = 0, m_lat = 0;
   logic [2:0]  m_op = 0;
   logic [16:0] m_addr = 0;
   logic [7:0]  m_dat = 0, m_rdata = 0;
   bit          launch;

   always @(posedge clk) begin
      // RAM updates caused by the cycle that just ended (happen even on a reset edge)
      if (m_busy && !m_oe_c && !m_ae_c) begin
         if (m_op == 3'd1 && m_k == 1) gold[m_addr[3:0]] = m_dat;
         if (m_op == 3'd3 && m_k >= 1 && m_k <= DEPTH) gold[m_k-1] = m_dat;
      end
      if (rst) begin
         m_busy = 0; m_k = 0; m_prev_en = 1; m_done = 0; m_operr = 0; m_adderr = 0;
         m_rdata = 0; m_rst_edge = 1;
      end else begin
         m_rst_edge = 0;
         launch = en && !m_prev_en;
         m_prev_en = en;
         if (m_busy) begin
            m_k++;
            if (m_k == 1) begin m_operr = m_oe_c; m_adderr = m_ae_c; end
            if (!m_oe_c && !m_ae_c && m_op == 3'd2 && m_k == RD_LAT + 2) m_rdata = gold[m_addr[3:0]];
            if (m_k == m_lat) begin m_busy = 0; m_done = 1; end
         end else if (launch) begin
            m_op = instr[2:0]; m_addr = instr[19:3]; m_dat = instr[27:20];
            m_oe_c = (m_op > 3'd3);
`ifdef PIO_CMD_PARITY_EN
            if (^instr) m_oe_c = 1;
`endif
            m_ae_c = !m_oe_c && (m_op == 3'd1 || m_op == 3'd2) && (m_addr >= 17'(DEPTH));
            if (m_oe_c || m_ae_c)                 m_lat = 2;
            else if (m_op == 3'd0 || m_op == 3'd1) m_lat = 3;
            else if (m_op == 3'd2)                 m_lat = 3 + RD_LAT;
            else                                   m_lat = 2 + DEPTH;
            m_busy = 1; m_k = 0; m_done = 0; m_operr = 0; m_adderr = 0;
         end
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0, n_fail = 0;
   bit cmp_en = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         bit ok_cmd, exp_we;
         ok_cmd = m_busy && !m_oe_c && !m_ae_c;
         exp_we = ok_cmd && ((m_op == 3'd1 && m_k == 1) ||
                             (m_op == 3'd3 && m_k >= 1 && m_k <= DEPTH));
         chk("flags", 32'(flags), 32'({m_adderr, m_busy, m_operr, m_done}));
         chk("data_out", 32'(data_out), 32'(m_rdata));
         chk("mem_we", 32'(mif.mem_we), 32'(exp_we));
         if (exp_we) begin
            chk("mem_addr", 32'(mif.mem_addr), (m_op == 3'd3) ? 32'(m_k - 1) : 32'(m_addr));
            chk("mem_wdata", 32'(mif.mem_wdata), 32'(m_dat));
         end
         if (ok_cmd && m_op == 3'd2 && m_k >= 1 && m_k <= RD_LAT + 1)
            chk("rd_addr", 32'(mif.mem_addr), 32'(m_addr));
         if (m_rst_edge) begin
            chk("rst_addr", 32'(mif.mem_addr), 32'd0);
            chk("rst_wdata", 32'(mif.mem_wdata), 32'd0);
         end
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [28:0] mk(input logic [2:0] op, input logic [16:0] a,
                                      input logic [7:0] d, input bit bad);
      logic [27:0] body;
      body = {d, a, op};
      return {(^body) ^ bad, body};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic [28:0] w);
      instr = w; en = 1'b1;
      tick(1);
      en = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int i;
      i = 0;
      while (!flags[0] && i < 200) begin tick(1); i++; end
      chk({name, " done"}, 32'(flags[0]), 32'd1);
   endtask

   int we0;

   initial begin
      rst = 1'b1; en = 1'b1; instr = '0;
      tick(3);
      cmp_en = 1;
      chk("reset flags", 32'(flags), 32'h0);
      chk("reset data", 32'(data_out), 32'h0);
      chk("reset we", 32'(mif.mem_we), 32'h0);
      rst = 1'b0;
      tick(3);                                   // enable held high out of reset
      chk("no launch after reset", 32'(flags), 32'h0);
      en = 1'b0; tick(1);

      // WRITE 5 <- A7 then READ 5
      we0 = we_total;
      issue(mk(3'd1, 17'd5, 8'hA7, 0)); wait_done("write");
      chk("write flags", 32'(flags), 32'h1);
      chk("write we count", 32'(we_total - we0), 32'd1);
      issue(mk(3'd2, 17'd5, 8'h00, 0));
      tick(4);
      chk("read busy at +5-1", 32'(flags), 32'h4);
      tick(1);
      chk("read done at +5", 32'(flags), 32'h1);
      chk("read data", 32'(data_out), 32'hA7);

      // Illegal opcode 6
      we0 = we_total;
      issue(mk(3'd6, 17'd1, 8'h12, 0));
      tick(1);
      chk("illegal +1", 32'(flags), 32'h6);
      tick(1);
      chk("illegal +2", 32'(flags), 32'h3);
      chk("illegal data kept", 32'(data_out), 32'hA7);
      chk("illegal no we", 32'(we_total - we0), 32'd0);

      // Address errors at the boundary and at the full-size depth
      issue(mk(3'd2, 17'd16, 8'h00, 0)); wait_done("rd16");
      chk("addr_err 16", 32'(flags), 32'h9);
      issue(mk(3'd2, 17'd76800, 8'h00, 0)); wait_done("rd76800");
      chk("addr_err 76800", 32'(flags), 32'h9);
      issue(mk(3'd1, 17'd15, 8'h5A, 0)); wait_done("wr15");
      chk("addr_err cleared", 32'(flags), 32'h1);

      // FILL 3C with an ignored second launch
      we0 = we_total;
      issue(mk(3'd3, 17'd9, 8'h3C, 0));
      tick(3);
      issue(mk(3'd1, 17'd3, 8'h11, 0));
      wait_done("fill");
      chk("fill we count", 32'(we_total - we0), 32'd16);
      for (int i = 0; i < 4; i++) begin
         logic [16:0] a;
         a = (i == 0) ? 17'd0 : (i == 1) ? 17'd7 : (i == 2) ? 17'd15 : 17'd3;
         issue(mk(3'd2, a, 8'h00, 0)); wait_done("fill rd");
         chk("fill readback", 32'(data_out), 32'h3C);
      end

      // NOP latency
      issue(mk(3'd0, 17'd0, 8'h00, 0));
      tick(2);
      chk("nop busy", 32'(flags), 32'h4);
      tick(1);
      chk("nop done", 32'(flags), 32'h1);

      // Reset at FILL address 6 with enable held high
      instr = mk(3'd3, 17'd0, 8'h55, 0); en = 1'b1;
      tick(8);
      chk("fill addr before reset", 32'(mif.mem_addr), 32'd6);
      rst = 1'b1; tick(1);
      chk("mid-fill reset flags", 32'(flags), 32'h0);
      chk("mid-fill reset data", 32'(data_out), 32'h0);
      chk("mid-fill reset we", 32'(mif.mem_we), 32'h0);
      rst = 1'b0; tick(4);
      chk("held enable no launch", 32'(flags), 32'h0);
      en = 1'b0; tick(1);
      issue(mk(3'd2, 17'd6, 8'h00, 0)); wait_done("rd6");
      chk("partial fill addr6", 32'(data_out), 32'h55);
      issue(mk(3'd2, 17'd7, 8'h00, 0)); wait_done("rd7");
      chk("untouched addr7", 32'(data_out), 32'h3C);

`ifdef PIO_CMD_PARITY_EN
      we0 = we_total;
      issue(mk(3'd1, 17'd2, 8'h99, 1)); wait_done("bad parity");
      chk("bad parity flags", 32'(flags), 32'h3);
      chk("bad parity no we", 32'(we_total - we0), 32'd0);
      issue(mk(3'd1, 17'd2, 8'h99, 0)); wait_done("good parity");
      chk("good parity flags", 32'(flags), 32'h1);
      issue(mk(3'd2, 17'd2, 8'h00, 0)); wait_done("rd2");
      chk("good parity data", 32'(data_out), 32'h99);
`endif

      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
